lpf_threshold_self_trigger: RTL
===============================

Name: lpf_threshold_self_trigger

Overview:
Self-trigger detector that sits directly downstream of the k low-pass filter in the selftrigger chain. It consumes the filtered 16-bit signed stream and subtracts a supplied baseline. It fires a one-cycle trigger when the excess stays above threshold for MIN_ABOVE consecutive samples. It then tracks the pulse until the excess falls below the hysteresis level, reports peak and width, and enforces a holdoff before re-arming.

Parameters:
MIN_ABOVE, 4, consecutive above-threshold samples required to fire; legal range 1..255
HOLDOFF, 64, enabled samples ignored after pulse end; legal range 0..65535

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  sample-valid qualifier; same cadence as filter enable
din  in  16  signed filtered sample (filter y output)
baseline  in  16  signed baseline level
threshold  in  14  unsigned trigger level above baseline
hyst  in  14  unsigned hysteresis; lower level = threshold - hyst
trigger  out  1  one-cycle pulse on detection
pulse_done  out  1  one-cycle pulse when tracked pulse ends
trig_peak  out  16  signed max excess of last completed pulse
trig_width  out  16  sample count of last completed pulse
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is clk-synchronous and active-high. All outputs go to 0, state goes to IDLE, and all counters and registers clear. Reset during ACTIVE or HOLDOFF aborts the pulse: no pulse_done, and peak/width are not updated.
- Stage 1 (capture): on each edge with enable=1, din and baseline are registered. A sample flag is registered alongside.
- Stage 2 (evaluate): the flagged sample is evaluated one edge later.
  - excess = din_r - baseline_r, computed as 17-bit signed with no overflow.
  - Upper compare: excess >= threshold, with threshold zero-extended.
  - Lower compare: excess < (threshold - hyst), computed as 17-bit signed. The lower level may be negative.
  - threshold and hyst are used live; a change takes effect on the next evaluated sample.
- While enable=0, no capture or evaluation occurs. State, counters and outputs hold, except that the one-cycle pulses deassert.
- IDLE:
  - run_cnt increments on each above sample and clears on a below sample.
  - run_cnt resets to 0 when leaving IDLE.
  - When run_cnt reaches MIN_ABOVE, trigger=1 for exactly one clk and state goes to ACTIVE.
  - peak_acc and width_acc are seeded from the MIN_ABOVE run: peak_acc is the max excess over the run, width_acc = MIN_ABOVE.
- ACTIVE:
  - Each evaluated sample not satisfying the lower compare updates peak_acc = max and increments width_acc. width_acc saturates at 65535.
  - The first sample satisfying the lower compare moves the state to HOLDOFF. That sample is not counted.
  - On the same edge, pulse_done=1 for one clk, and trig_peak / trig_width load.
  - trig_peak is excess saturated to [-32768, 32767].
- HOLDOFF:
  - hold_cnt counts evaluated samples.
  - When hold_cnt >= HOLDOFF and the current sample satisfies the lower compare, state goes to IDLE with run_cnt = 0.
  - Otherwise the state remains HOLDOFF; it waits until the signal is below the lower level.
  - With HOLDOFF = 0, the re-arm check applies from the first evaluated sample.
- Latency: with continuous enable, sample k is presented in cycle k and evaluated at the end of cycle k+1. trigger and pulse_done are high in cycle k+2, where k is the deciding sample.
- trigger and pulse_done are registered and never high together. A single-sample drop is still a full pulse end.
- busy is registered and equals (state != IDLE).

Test Plan:
- Reset: assert reset 3 cycles while driving din=1000 -> all outputs 0 and busy=0; after release with din=baseline, no trigger.
- Basic fire (baseline=100, threshold=50, hyst=10, MIN_ABOVE=4, HOLDOFF=64): din=160 for 10 samples, then 100 continuously.
  - trigger is high one cycle, 2 cycles after the 4th 160 sample.
  - pulse_done is high 2 cycles after the first 100 sample, with trig_peak=60 and trig_width=10.
- Glitch reject: 3 samples at 160 then 100 -> no trigger, busy stays 0. Then 4 samples at 160 -> trigger.
- Hysteresis: after trigger, din=145 (excess 45 >= 40) keeps ACTIVE. din=139 (excess 39) ends the pulse; trig_width counts the 145 samples but not the 139 sample.
- Holdoff (HOLDOFF=8): a second 160 burst 3 samples after pulse_done -> no trigger. The same burst 20 samples after pulse_done, with din=100 between bursts -> trigger.
- Enable gating and saturation:
  - Gating: toggle enable 1/0 during a 160 run -> trigger only after 4 enabled samples, and no pulse output while enable=0.
  - Saturation: din=32767, baseline=-32768, threshold=100 -> trig_peak=32767.

Source files
------------

// File: rtl/lpf_threshold_self_trigger.sv
// Threshold self-trigger on the low-pass-filtered stream: baseline subtraction,
// MIN_ABOVE run qualification, hysteresis pulse tracking and holdoff re-arm.
module lpf_threshold_self_trigger #(
    parameter int unsigned MIN_ABOVE = 4,
    parameter int unsigned HOLDOFF   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic signed [15:0] din,
    input  logic signed [15:0] baseline,
    input  logic        [13:0] threshold,
    input  logic        [13:0] hyst,
    output logic               trigger,
    output logic               pulse_done,
    output logic signed [15:0] trig_peak,
    output logic        [15:0] trig_width,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HOLD
    } state_t;

    state_t             state, state_n;
    logic signed [15:0] din_r, base_r;
    logic               smp_vld;
    logic        [7:0]  run_cnt, run_cnt_n;
    logic signed [16:0] run_max, run_max_n;
    logic signed [16:0] peak_acc, peak_acc_n;
    logic        [15:0] width_acc, width_acc_n;
    logic        [15:0] hold_cnt, hold_cnt_n;
    logic               trigger_n, pulse_done_n;
    logic signed [15:0] trig_peak_n;
    logic        [15:0] trig_width_n;

    logic signed [16:0] excess, upper_lvl, lower_lvl, run_peak;
    logic               eval, above, below_low;

    // Stage 1: capture; the flag holds across disabled cycles so a captured
    // sample is evaluated on the next enabled edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_r   <= '0;
            base_r  <= '0;
            smp_vld <= 1'b0;
        end else if (enable) begin
            din_r   <= din;
            base_r  <= baseline;
            smp_vld <= 1'b1;
        end
    end

    assign eval      = enable && smp_vld;
    assign excess    = 17'(din_r) - 17'(base_r);
    assign upper_lvl = $signed({3'b000, threshold});
    assign lower_lvl = $signed({3'b000, threshold}) - $signed({3'b000, hyst});
    assign above     = (excess >= upper_lvl);
    assign below_low = (excess < lower_lvl);
    assign run_peak  = (run_cnt == 8'd0 || excess > run_max) ? excess : run_max;

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v > 17'sd32767)       return 16'sh7FFF;
        else if (v < -17'sd32768) return 16'sh8000;
        else                      return v[15:0];
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_n      = state;
        run_cnt_n    = run_cnt;
        run_max_n    = run_max;
        peak_acc_n   = peak_acc;
        width_acc_n  = width_acc;
        hold_cnt_n   = hold_cnt;
        trigger_n    = 1'b0;
        pulse_done_n = 1'b0;
        trig_peak_n  = trig_peak;
        trig_width_n = trig_width;

        if (eval) begin
            unique case (state)
                IDLE: begin
                    if (above) begin
                        if (({1'b0, run_cnt} + 9'd1) == 9'(MIN_ABOVE)) begin
                            trigger_n   = 1'b1;
                            state_n     = ACTIVE;
                            run_cnt_n   = '0;
                            peak_acc_n  = run_peak;
                            width_acc_n = 16'(MIN_ABOVE);
                        end else begin
                            run_cnt_n = run_cnt + 8'd1;
                            run_max_n = run_peak;
                        end
                    end else begin
                        run_cnt_n = '0;
                    end
                end
                ACTIVE: begin
                    if (below_low) begin
                        state_n      = HOLD;
                        pulse_done_n = 1'b1;
                        trig_peak_n  = sat16(peak_acc);
                        trig_width_n = width_acc;
                        hold_cnt_n   = '0;
                    end else begin
                        if (excess > peak_acc) peak_acc_n = excess;
                        if (width_acc != 16'hFFFF) width_acc_n = width_acc + 16'd1;
                    end
                end
                HOLD: begin
                    if (hold_cnt >= 16'(HOLDOFF) && below_low) begin
                        state_n   = IDLE;
                        run_cnt_n = '0;
                    end else if (hold_cnt != 16'hFFFF) begin
                        hold_cnt_n = hold_cnt + 16'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            run_cnt    <= '0;
            run_max    <= '0;
            peak_acc   <= '0;
            width_acc  <= '0;
            hold_cnt   <= '0;
            trigger    <= 1'b0;
            pulse_done <= 1'b0;
            trig_peak  <= '0;
            trig_width <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            run_cnt    <= run_cnt_n;
            run_max    <= run_max_n;
            peak_acc   <= peak_acc_n;
            width_acc  <= width_acc_n;
            hold_cnt   <= hold_cnt_n;
            trigger    <= trigger_n;
            pulse_done <= pulse_done_n;
            trig_peak  <= trig_peak_n;
            trig_width <= trig_width_n;
            busy       <= (state_n != IDLE);
        end
    end

endmodule
